main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder_pkg.sv | 27 ++
 rtl/main_mem_responder_if.sv | 35 +++
 rtl/main_mem_responder_latency_counter.sv | 36 +++
 rtl/main_mem_responder.sv | 140 ++++++++++++++
 tb/tb_main_mem_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg
// Shared definitions for the main-memory end of the memory hierarchy:
// the responder FSM state type and the default geometry and latency.
// No ports; the other files import it with
//    import main_mem_responder_pkg::*;
package main_mem_responder_pkg;

   // Default geometry of main memory: 32 words of 16 bits.
   localparam int MEM_ADDR_W  = 5;
   localparam int MEM_DATA_W  = 16;

   // Default accept-to-response latency in cycles. The legal range is 1..15.
   localparam int MEM_LATENCY = 4;

   // The hierarchy carries full 16-bit word addresses on its bus.
   localparam int BUS_ADDR_W  = 16;

   // The latency counter is 4 bits wide, which is enough for LATENCY-1 <= 14.
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if
// Request/response bus between an initiator (the cache side) and the
// main-memory responder.
//   req_valid/req_write/req_addr/req_wdata : request from the initiator
//   req_ready                              : responder can accept this cycle
//   resp_valid/resp_rdata/resp_err         : held response from the responder
//   resp_ready                             : initiator consumes the response
// Modports: master = initiator side, slave = responder side.
interface main_mem_responder_if
   import main_mem_responder_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W
);

   logic                  req_valid;
   logic                  req_write;
   logic [BUS_ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  req_ready;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  resp_err;
   logic                  resp_ready;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/main_mem_responder_latency_counter.sv
// latency_counter
// Down-counter that paces the responder's WAIT state.
//   clock, reset : rising-edge clock and synchronous active-high reset
//   load         : load load_value (this takes priority over dec)
//   dec          : decrement by one; the counter holds at zero
//   load_value   : value to load
//   zero         : the count is zero
module latency_counter
#(
   parameter int CNT_W = 4
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // The count register. Load wins over decrement. The counter saturates
   // at zero, so an unexpected extra dec cannot wrap it around.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder
// Register-based main memory that sits at the bottom of the hierarchy. It
// accepts one request at a time. The response is presented LATENCY cycles
// after the request is accepted, and it is held until the initiator takes it.
//   clock, reset : rising-edge clock and synchronous active-high reset
//   bus          : slave side of main_mem_responder_if (request/response)
//   busy         : FSM is not IDLE (drives a status LED)
// After reset every word holds its own index, so read data is predictable.
module main_mem_responder
   import main_mem_responder_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int LATENCY = MEM_LATENCY
)(
   input  logic                clock,
   input  logic                reset,
   main_mem_responder_if.slave bus,
   output logic                busy
);

   localparam int                DEPTH      = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0]  LOAD_VALUE = CNT_W'(LATENCY - 1);

   state_t            state;
   state_t            next_state;
   logic              accept;
   logic              execute;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;

   logic              op_write;
   logic              op_err;
   logic [ADDR_W-1:0] op_idx;
   logic [DATA_W-1:0] op_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [DATA_W-1:0] mem [DEPTH];

   latency_counter #(.CNT_W(CNT_W)) u_latency_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_value (LOAD_VALUE),
      .zero       (cnt_zero)
   );

   // The state register. Reset wins over everything else, which also
   // abandons any transaction that is in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. The counter is loaded with LATENCY-1
   // on accept. The operation runs on the WAIT edge that sees zero, so
   // RESP starts exactly LATENCY edges after the accept edge. RESP always
   // returns to IDLE rather than accepting a new request, which keeps a
   // retire and a new accept from landing in the same cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      execute    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept     = 1'b1;
               cnt_load   = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               execute    = 1'b1;
               next_state = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Request capture, the memory array and the response registers.
   // Any nonzero address bit above ADDR_W marks the request as an error
   // instead of aliasing onto a low word. Error requests touch nothing and
   // return zero data.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_write <= 1'b0;
         op_err   <= 1'b0;
         op_idx   <= '0;
         op_wdata <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= DATA_W'(i);
         end
      end else begin
         if (accept) begin
            op_write <= bus.req_write;
            op_err   <= (bus.req_addr >> ADDR_W) != '0;
            op_idx   <= bus.req_addr[ADDR_W-1:0];
            op_wdata <= bus.req_wdata;
         end
         if (execute) begin
            if (op_err) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end else if (op_write) begin
               mem[op_idx] <= op_wdata;
               rdata_q     <= '0;
               err_q       <= 1'b0;
            end else begin
               rdata_q <= mem[op_idx];
               err_q   <= 1'b0;
            end
         end
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder
// Directed bench for main_mem_responder. Each issued request pushes its
// hand-computed response onto a queue. An independent monitor pops from
// the queue when a response appears and checks data, error flag, latency
// and hold-stability.
module tb_main_mem_responder;

   localparam int LATENCY = 4;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          accept_cycle;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy;
   int   cycle = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   in_resp = 1'b0;
   exp_t exp_q[$];
   exp_t cur;

   main_mem_responder_if #(.DATA_W(16)) bus ();

   main_mem_responder #(.ADDR_W(5), .DATA_W(16), .LATENCY(LATENCY)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   // The free-running clock and a cycle count used for the latency checks.
   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Compare one value and report it when it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Wait for req_ready, then present one request for a single accept edge.
   // This task is entered and left at posedge+1.
   task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input logic exp_err, input bit expect_resp);
      int   waited = 0;
      exp_t e;
      while (!bus.req_ready && waited < 100) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!bus.req_ready) begin
         checkOutput("req_ready_timeout", 32'd0, 32'd1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      if (expect_resp) begin
         e.rdata        = exp_rdata;
         e.err          = exp_err;
         e.accept_cycle = cycle;
         exp_q.push_back(e);
      end
   endtask

   // Wait until every expected response has been retired and the DUT is idle.
   task automatic waitIdle();
      int waited = 0;
      while (!(exp_q.size() == 0 && !in_resp && !bus.resp_valid && !busy) && waited < 200) begin
         @(posedge clock); #1;
         waited++;
      end
      checkOutput("drain_timeout", 32'(waited >= 200), 32'd0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // The monitor samples on the falling edge, away from DUT updates. It
   // pops when a new response appears and rechecks the held values on
   // every later cycle until the response is consumed.
   always @(negedge clock) begin
      if (reset) begin
         in_resp = 1'b0;
      end else if (bus.resp_valid) begin
         if (!in_resp) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
               cur     = exp_q.pop_front();
               in_resp = 1'b1;
               checkOutput("latency", 32'(cycle - cur.accept_cycle), 32'(LATENCY));
               checkOutput("resp_rdata", 32'(bus.resp_rdata), 32'(cur.rdata));
               checkOutput("resp_err", 32'(bus.resp_err), 32'(cur.err));
            end
         end else begin
            checkOutput("hold_rdata", 32'(bus.resp_rdata), 32'(cur.rdata));
            checkOutput("hold_err", 32'(bus.resp_err), 32'(cur.err));
         end
         if (bus.resp_ready) in_resp = 1'b0;
      end
   end

   // Watchdog, so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // The directed sequence.
   initial begin
      int waited;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Outputs straight after reset.
      checkIdleOutputs("reset");
      checkOutput("reset_resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("reset_resp_rdata", 32'(bus.resp_rdata), 32'd0);

      // Read addr 7 returns its reset value. Also check busy during WAIT.
      applyStimulus(1'b0, 16'd7, 16'h0, 16'h0007, 1'b0, 1'b1);
      checkOutput("wait_busy", 32'(busy), 32'd1);
      checkOutput("wait_req_ready", 32'(bus.req_ready), 32'd0);
      waitIdle();

      // Write then read back the same address.
      applyStimulus(1'b1, 16'd12, 16'h03FF, 16'h0000, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'd12, 16'h0, 16'h03FF, 1'b0, 1'b1);
      waitIdle();

      // Stall the response for 10 cycles. It is released one edge after resp_ready.
      bus.resp_ready = 1'b0;
      applyStimulus(1'b0, 16'd5, 16'h0, 16'h0005, 1'b0, 1'b1);
      waited = 0;
      while (!bus.resp_valid && waited < 50) begin
         @(posedge clock); #1;
         waited++;
      end
      checkOutput("stall_resp_seen", 32'(bus.resp_valid), 32'd1);
      repeat (10) begin
         @(posedge clock); #1;
      end
      checkOutput("stall_still_valid", 32'(bus.resp_valid), 32'd1);
      bus.resp_ready = 1'b1;
      @(posedge clock); #1;
      checkIdleOutputs("release");
      waitIdle();

      // Out-of-range write, with no aliasing onto addr 0 or addr 1.
      applyStimulus(1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b1, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'h0021, 16'h0, 16'h0000, 1'b1, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'hFFFF, 16'h0, 16'h0000, 1'b1, 1'b1);
      waitIdle();

      // Top in-range word.
      applyStimulus(1'b0, 16'd31, 16'h0, 16'h001F, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(1'b1, 16'd31, 16'hA5A5, 16'h0000, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'd31, 16'h0, 16'hA5A5, 1'b0, 1'b1);
      waitIdle();

      // Reset during WAIT aborts the write, and no response follows.
      applyStimulus(1'b1, 16'd3, 16'hBEEF, 16'h0, 1'b0, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkIdleOutputs("abort");
      checkOutput("abort_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      repeat (LATENCY + 4) begin
         @(posedge clock); #1;
      end
      applyStimulus(1'b0, 16'd3, 16'h0, 16'h0003, 1'b0, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 16'd12, 16'h0, 16'h000C, 1'b0, 1'b1);
      waitIdle();

      // A req_valid pulse during WAIT is ignored.
      applyStimulus(1'b0, 16'd9, 16'h0, 16'h0009, 1'b0, 1'b1);
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'd20;
      bus.req_wdata = 16'h5555;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      waitIdle();
      repeat (LATENCY + 4) begin
         @(posedge clock); #1;
      end
      applyStimulus(1'b0, 16'd20, 16'h0, 16'h0014, 1'b0, 1'b1);
      waitIdle();

      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
